regfile_writeback: RTL and testbench
====================================

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4 (power of two, >=2), the number of load-result buffer entries.
REQ-002 The block SHALL have parameter XLEN, default 64, the register data width.
REQ-003 The block SHALL have these ports:
- CLK  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- alu_v  in  1  ALU result valid; ALU results cannot be stalled.
- alu_dr  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- ld_v  in  1  load result valid.
- ld_rdy  out  1  load channel ready.
- ld_dr  in  5  load destination register.
- ld_funct3  in  3  load size/sign (LB/LH/LW/LD/LBU/LHU/LWU).
- ld_data  in  XLEN  raw load data, right-aligned.
- SR1  in  5  decode-stage source register 1.
- SR2  in  5  decode-stage source register 2.
- pend_sr1  out  1  a load write to SR1 is still pending.
- pend_sr2  out  1  a load write to SR2 is still pending.
- DR  out  5  register-file write address.
- WB_DATA  out  XLEN  register-file write data.
- ST_REG  out  1  register-file write enable.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.

Function
REQ-004 DR, WB_DATA and ST_REG SHALL be registered; a write selected in cycle N appears in cycle N+1 for exactly one cycle.
REQ-005 ALU results SHALL have absolute priority: if alu_v=1, the next-cycle write is the ALU write.
REQ-006 ld_rdy SHALL equal (fifo_count < FIFO_DEPTH), from registered state only; a load is accepted when ld_v and ld_rdy are both 1.
REQ-007 Accepted load data SHALL be extended at acceptance:
- funct3 000: sign-extend [7:0]; 100: zero-extend [7:0].
- funct3 001: sign-extend [15:0]; 101: zero-extend [15:0].
- funct3 010: sign-extend [31:0]; 110: zero-extend [31:0].
- funct3 011 or 111: full 64 bits.
REQ-008 When alu_v=0, the head FIFO entry SHALL be popped and written; if the FIFO is empty, a load accepted that cycle SHALL bypass the FIFO and be written next cycle.
REQ-009 Push and pop in the same cycle SHALL leave fifo_count unchanged; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-010 A full FIFO SHALL NOT accept a push even if it pops the same cycle.
REQ-011 A write with destination x0 SHALL produce ST_REG=0; a load to x0 SHALL be accepted and discarded, and SHALL NOT be enqueued.
REQ-012 pend_srN SHALL be 1 iff SRN!=0 and SRN matches:
- the dr of any occupied FIFO entry, or
- ld_dr of a load accepted this cycle, or
- the registered DR while ST_REG=1.
REQ-013 Load results to the same register SHALL be written in acceptance order.

Reset
REQ-014 On reset=1 at a rising edge, the block SHALL set DR=0, WB_DATA=0, ST_REG=0, both pointers=0 and fifo_count=0; buffered loads are discarded.
REQ-015 ALU and load inputs present during a reset cycle SHALL be ignored; ld_rdy SHALL be 1 in the first cycle after reset.

Structure
REQ-016 A shared package SHALL hold XLEN, the default FIFO_DEPTH and the seven load funct3 encodings.
REQ-017 The buffer SHALL be a sub-module wb_load_fifo holding {dr, extended data} entries; extension and arbitration SHALL stay in the top module.

Verification
REQ-018 alu_v=1, alu_dr=5, alu_data=0x1234 -> next cycle DR=5, WB_DATA=0x1234, ST_REG=1; the cycle after, ST_REG=0.
REQ-019 ld_v=1, ld_funct3=000, ld_data=0x80, ld_dr=7, FIFO empty, alu_v=0 -> next cycle WB_DATA=0xFFFFFFFFFFFFFF80, DR=7; repeat with funct3=100 -> WB_DATA=0x80.
REQ-020 alu_v held at 1 for 6 cycles while ld_v=1 to regs 1..4 -> fifo_count reaches 4 and ld_rdy=0; after alu_v drops, regs 1,2,3,4 are written in order on consecutive cycles.
REQ-021 alu_dr=0 with alu_v=1 -> ST_REG stays 0; a load to x0 is accepted and never written.
REQ-022 FIFO holds a load to x9, SR1=9, SR2=0 -> pend_sr1=1, pend_sr2=0; pend_sr1 falls the cycle after the x9 write completes.
REQ-023 Assert reset with 3 entries buffered -> next cycle fifo_count=0, ST_REG=0, ld_rdy=1; no buffered load is ever written.

Source files
------------

// File: rtl/regfile_writeback_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_writeback_pkg: shared widths, buffer depth and load encodings.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package regfile_writeback_pkg;

    localparam int XLEN               = 64;
    localparam int FIFO_DEPTH_DEFAULT = 4;
    localparam int REG_AW             = 5;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LD  = 3'b011,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101,
        F3_LWU = 3'b110
    } ld_funct3_e;

endpackage
`default_nettype wire

// File: rtl/wb_load_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_load_fifo: circular buffer of {dr, extended data} load results.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module wb_load_fifo #(
    parameter  int DEPTH = 4,
    parameter  int DW    = 64,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                push,
    input  logic [4:0]          push_dr,
    input  logic [DW-1:0]       push_data,
    input  logic                pop,
    output logic [4:0]          head_dr,
    output logic [DW-1:0]       head_data,
    output logic [CW-1:0]       count,
    output logic [DEPTH-1:0]    occ_valid,
    output logic [DEPTH*5-1:0]  occ_dr
);
    import regfile_writeback_pkg::*;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic [REG_AW-1:0] dr_mem_q   [DEPTH];
    logic [REG_AW-1:0] dr_mem_d   [DEPTH];
    logic [DW-1:0]     data_mem_q [DEPTH];
    logic [DW-1:0]     data_mem_d [DEPTH];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        dr_mem_d   = dr_mem_q;
        data_mem_d = data_mem_q;
        if (push) begin
            dr_mem_d[wr_ptr_q]   = push_dr;
            data_mem_d[wr_ptr_q] = push_data;
            wr_ptr_d             = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is qualified by the pointers, so it needs no reset.
    always_ff @(posedge CLK) begin
        dr_mem_q   <= dr_mem_d;
        data_mem_q <= data_mem_d;
    end

    assign head_dr   = dr_mem_q[rd_ptr_q];
    assign head_data = data_mem_q[rd_ptr_q];
    assign count     = count_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_occ
        logic [PW-1:0] w_off;
        assign w_off           = PW'(i) - rd_ptr_q;
        assign occ_valid[i]    = ({1'b0, w_off} < count_q);
        assign occ_dr[i*5 +: 5] = dr_mem_q[i];
    end

endmodule
`default_nettype wire

// File: rtl/regfile_writeback.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_writeback: arbitrates ALU and load results onto the RF write.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module regfile_writeback #(
    parameter  int FIFO_DEPTH = regfile_writeback_pkg::FIFO_DEPTH_DEFAULT,
    parameter  int XLEN       = regfile_writeback_pkg::XLEN,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            alu_v,
    input  logic [4:0]      alu_dr,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_v,
    output logic            ld_rdy,
    input  logic [4:0]      ld_dr,
    input  logic [2:0]      ld_funct3,
    input  logic [XLEN-1:0] ld_data,
    input  logic [4:0]      SR1,
    input  logic [4:0]      SR2,
    output logic            pend_sr1,
    output logic            pend_sr2,
    output logic [4:0]      DR,
    output logic [XLEN-1:0] WB_DATA,
    output logic            ST_REG,
    output logic [CW-1:0]   fifo_count
);
    import regfile_writeback_pkg::*;

    logic [4:0]            dr_q, dr_d;
    logic [XLEN-1:0]       wb_data_q, wb_data_d;
    logic                  st_reg_q, st_reg_d;

    logic                  w_push, w_pop, w_ld_acc, w_empty;
    logic [XLEN-1:0]       w_ld_ext;
    logic [4:0]            w_head_dr;
    logic [XLEN-1:0]       w_head_data;
    logic [CW-1:0]         w_count;
    logic [FIFO_DEPTH-1:0] w_occ_valid;
    logic [FIFO_DEPTH*5-1:0] w_occ_dr;
    logic                  w_hit1, w_hit2;

    wb_load_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (XLEN)
    ) u_fifo (
        .CLK       (CLK),
        .reset     (reset),
        .push      (w_push),
        .push_dr   (ld_dr),
        .push_data (w_ld_ext),
        .pop       (w_pop),
        .head_dr   (w_head_dr),
        .head_data (w_head_data),
        .count     (w_count),
        .occ_valid (w_occ_valid),
        .occ_dr    (w_occ_dr)
    );

    assign ld_rdy   = (w_count < CW'(FIFO_DEPTH));
    assign w_ld_acc = ld_v & ld_rdy;
    assign w_empty  = (w_count == '0);

    always_comb begin
        w_ld_ext = ld_data;
        case (ld_funct3)
            F3_LB:   w_ld_ext = {{(XLEN-8){ld_data[7]}},   ld_data[7:0]};
            F3_LBU:  w_ld_ext = {{(XLEN-8){1'b0}},         ld_data[7:0]};
            F3_LH:   w_ld_ext = {{(XLEN-16){ld_data[15]}}, ld_data[15:0]};
            F3_LHU:  w_ld_ext = {{(XLEN-16){1'b0}},        ld_data[15:0]};
            F3_LW:   w_ld_ext = {{(XLEN-32){ld_data[31]}}, ld_data[31:0]};
            F3_LWU:  w_ld_ext = {{(XLEN-32){1'b0}},        ld_data[31:0]};
            default: w_ld_ext = ld_data;
        endcase
    end

    // ALU wins outright; otherwise drain the buffer, bypassing it only when empty
    // so that loads to one register retire in acceptance order.
    always_comb begin
        w_push    = 1'b0;
        w_pop     = 1'b0;
        dr_d      = dr_q;
        wb_data_d = wb_data_q;
        st_reg_d  = 1'b0;
        if (alu_v) begin
            dr_d      = alu_dr;
            wb_data_d = alu_data;
            st_reg_d  = (alu_dr != 5'd0);
            w_push    = w_ld_acc && (ld_dr != 5'd0);
        end else if (!w_empty) begin
            w_pop     = 1'b1;
            dr_d      = w_head_dr;
            wb_data_d = w_head_data;
            st_reg_d  = 1'b1;
            w_push    = w_ld_acc && (ld_dr != 5'd0);
        end else if (w_ld_acc) begin
            dr_d      = ld_dr;
            wb_data_d = w_ld_ext;
            st_reg_d  = (ld_dr != 5'd0);
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            dr_q      <= '0;
            wb_data_q <= '0;
            st_reg_q  <= 1'b0;
        end else begin
            dr_q      <= dr_d;
            wb_data_q <= wb_data_d;
            st_reg_q  <= st_reg_d;
        end
    end

    always_comb begin
        w_hit1 = 1'b0;
        w_hit2 = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (w_occ_valid[i] && (w_occ_dr[i*5 +: 5] == SR1)) w_hit1 = 1'b1;
            if (w_occ_valid[i] && (w_occ_dr[i*5 +: 5] == SR2)) w_hit2 = 1'b1;
        end
        if (w_ld_acc && (ld_dr == SR1)) w_hit1 = 1'b1;
        if (w_ld_acc && (ld_dr == SR2)) w_hit2 = 1'b1;
        if (st_reg_q && (dr_q == SR1))  w_hit1 = 1'b1;
        if (st_reg_q && (dr_q == SR2))  w_hit2 = 1'b1;
    end

    assign pend_sr1   = (SR1 != 5'd0) && w_hit1;
    assign pend_sr2   = (SR2 != 5'd0) && w_hit2;
    assign DR         = dr_q;
    assign WB_DATA    = wb_data_q;
    assign ST_REG     = st_reg_q;
    assign fifo_count = w_count;

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_regfile_writeback: directed + random stimulus against a queue model.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_regfile_writeback;

    localparam int C_DEPTH = 4;
    localparam int C_XLEN  = 64;

    logic              CLK;
    logic              reset;
    logic              alu_v;
    logic [4:0]        alu_dr;
    logic [C_XLEN-1:0] alu_data;
    logic              ld_v;
    logic              ld_rdy;
    logic [4:0]        ld_dr;
    logic [2:0]        ld_funct3;
    logic [C_XLEN-1:0] ld_data;
    logic [4:0]        SR1, SR2;
    logic              pend_sr1, pend_sr2;
    logic [4:0]        DR;
    logic [C_XLEN-1:0] WB_DATA;
    logic              ST_REG;
    logic [2:0]        fifo_count;

    regfile_writeback #(.FIFO_DEPTH(C_DEPTH), .XLEN(C_XLEN)) dut (
        .CLK(CLK), .reset(reset),
        .alu_v(alu_v), .alu_dr(alu_dr), .alu_data(alu_data),
        .ld_v(ld_v), .ld_rdy(ld_rdy), .ld_dr(ld_dr), .ld_funct3(ld_funct3),
        .ld_data(ld_data), .SR1(SR1), .SR2(SR2),
        .pend_sr1(pend_sr1), .pend_sr2(pend_sr2),
        .DR(DR), .WB_DATA(WB_DATA), .ST_REG(ST_REG), .fifo_count(fifo_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0]  dr;
        logic [63:0] data;
    } ent_t;

    ent_t        q[$];
    logic        cur_st;
    logic [4:0]  cur_dr;
    logic [63:0] cur_data;
    bit          synced;
    int          n_checks;
    int          n_fail;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] extend(input logic [2:0] f3, input logic [63:0] d);
        case (f3)
            3'b000:  return 64'($signed(d[7:0]));
            3'b001:  return 64'($signed(d[15:0]));
            3'b010:  return 64'($signed(d[31:0]));
            3'b100:  return 64'(d[7:0]);
            3'b101:  return 64'(d[15:0]);
            3'b110:  return 64'(d[31:0]);
            default: return d;
        endcase
    endfunction

    function automatic bit pend_model(input logic [4:0] sr, input bit acc, input logic [4:0] l_dr);
        if (sr == 5'd0) return 1'b0;
        foreach (q[i]) if (q[i].dr == sr) return 1'b1;
        if (acc && l_dr == sr) return 1'b1;
        if (cur_st && cur_dr == sr) return 1'b1;
        return 1'b0;
    endfunction

    task automatic step(input logic rst, input logic a_v, input logic [4:0] a_dr,
                        input logic [63:0] a_data, input logic l_v, input logic [4:0] l_dr,
                        input logic [2:0] f3, input logic [63:0] l_data,
                        input logic [4:0] s1, input logic [4:0] s2);
        bit   acc;
        ent_t e;
        reset = rst; alu_v = a_v; alu_dr = a_dr; alu_data = a_data;
        ld_v = l_v; ld_dr = l_dr; ld_funct3 = f3; ld_data = l_data; SR1 = s1; SR2 = s2;
        #1;
        acc = l_v && (q.size() < C_DEPTH);
        if (synced) begin
            check("ld_rdy", 64'(ld_rdy), 64'(q.size() < C_DEPTH));
            check("pend_sr1", 64'(pend_sr1), 64'(pend_model(s1, acc, l_dr)));
            check("pend_sr2", 64'(pend_sr2), 64'(pend_model(s2, acc, l_dr)));
        end
        if (rst) begin
            q.delete();
            cur_st = 1'b0; cur_dr = '0; cur_data = '0;
        end else begin
            e.dr = l_dr; e.data = extend(f3, l_data);
            if (a_v) begin
                cur_st = (a_dr != 0); cur_dr = a_dr; cur_data = a_data;
                if (acc && l_dr != 0) q.push_back(e);
            end else if (q.size() > 0) begin
                cur_st = 1'b1; cur_dr = q[0].dr; cur_data = q[0].data;
                void'(q.pop_front());
                if (acc && l_dr != 0) q.push_back(e);
            end else if (acc) begin
                cur_st = (l_dr != 0); cur_dr = l_dr; cur_data = e.data;
            end else begin
                cur_st = 1'b0;
            end
        end
        @(posedge CLK); #1;
        if (rst) synced = 1'b1;
        if (synced) begin
            check("st_reg", 64'(ST_REG), 64'(cur_st));
            check("fifo_count", 64'(fifo_count), 64'(q.size()));
            if (cur_st || rst) begin
                check("dr", 64'(DR), 64'(cur_dr));
                check("wb_data", WB_DATA, cur_data);
            end
        end
    endtask

    task automatic idle(input int n, input logic [4:0] s1, input logic [4:0] s2);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, s1, s2);
    endtask

    initial begin
        n_checks = 0; n_fail = 0; synced = 1'b0;
        cur_st = 1'b0; cur_dr = '0; cur_data = '0;
        step(1, 1, 3, 64'hdead, 1, 4, 3'b011, 64'hbeef, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1, 0, 0);

        // Single ALU write, then sign/zero-extended byte load bypass.
        step(0, 1, 5, 64'h1234, 0, 0, 0, 0, 0, 0);
        idle(1, 0, 0);
        step(0, 0, 0, 0, 1, 7, 3'b000, 64'h80, 7, 0);
        step(0, 0, 0, 0, 1, 7, 3'b100, 64'h80, 7, 0);
        idle(1, 0, 0);

        // ALU hogs the port while four loads fill the buffer.
        for (int i = 0; i < 6; i++)
            step(0, 1, 5'(10 + i), 64'(i), 1, 5'(i < 4 ? i + 1 : 20), 3'b011, 64'(100 + i), 3, 0);
        idle(5, 3, 4);

        // x0 destinations never write.
        step(0, 1, 0, 64'h55, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 3'b011, 64'h77, 0, 0);
        idle(1, 0, 0);

        // Pending tracking on x9.
        step(0, 1, 1, 64'h1, 1, 9, 3'b010, 64'h8000_0000, 9, 0);
        step(0, 1, 2, 64'h2, 0, 0, 0, 0, 9, 0);
        idle(3, 9, 0);

        // Reset with three buffered loads.
        for (int i = 0; i < 3; i++)
            step(0, 1, 6, 64'(i), 1, 5'(11 + i), 3'b011, 64'hA0 + 64'(i), 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(4, 11, 12);

        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), {$urandom, $urandom},
                 ($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 {$urandom, $urandom}, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        idle(6, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
